// File: rtl/sound_mixer_n_if.sv
// CPU bus bundle for the sound mixer: the address/data/direction lines
// shared with the BRAM-style register decode.
interface sound_mixer_n_if;
  logic        should_read;
  logic [15:0] addr_to_bram;
  logic [7:0]  data_to_bram;
  logic [7:0]  data_from_bram;

  modport master (
    output should_read,
    output addr_to_bram,
    output data_to_bram,
    input  data_from_bram
  );

  modport slave (
    input  should_read,
    input  addr_to_bram,
    input  data_to_bram,
    output data_from_bram
  );
endinterface

// File: rtl/sound_mixer_n.sv
// Sound back-end: mixes NUM_CH channel samples with CPU-programmable gains
// and emits one saturated unsigned sample per 24 kHz tick.
module sound_mixer_n #(
  parameter int          NUM_CH    = 4,
  parameter int          IN_W      = 4,
  parameter int          OUT_W     = 16,
  parameter int          SHIFT     = 0,
  parameter logic [15:0] BASE_ADDR = 16'h1840,
  parameter int          MUTE_BIT  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_3MHz_en,
  input  logic                   clk_24KHz_en,
  sound_mixer_n_if.slave         bus,
  input  logic [NUM_CH*IN_W-1:0] ch_audio,
  output logic [7:0]             latch_out,
  output logic [OUT_W-1:0]       audio,
  output logic                   sample_valid
);

  localparam int ACC_W  = IN_W + 8 + $clog2(NUM_CH + 1);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WIDE_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 state, state_nx;
  logic [7:0]             latch;
  logic [7:0]             gain      [NUM_CH];
  logic [7:0]             gain_snap [NUM_CH];
  logic [NUM_CH*IN_W-1:0] ch_snap;
  logic                   overrun;
  logic [ACC_W-1:0]       acc;
  logic [IDX_W-1:0]       idx;

  logic [15:0]            offset;
  logic                   hit_latch, hit_status, wr_en, status_rd;
  logic [NUM_CH-1:0]      hit_gain;
  logic                   snap_load, acc_step, finish, ovr_set;
  logic [IN_W+8-1:0]      prod;
  logic [WIDE_W-1:0]      v_w;
  logic                   sat;
  logic [OUT_W-1:0]       mix_out;

  assign latch_out = latch;

  // Address decode
  always_comb begin
    offset     = bus.addr_to_bram - BASE_ADDR;
    hit_latch  = (offset == 16'd0);
    hit_status = (offset == 16'(NUM_CH + 1));
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit_gain[i] = (offset == 16'(i + 1));
    end
    wr_en     = clk_3MHz_en && !bus.should_read;
    status_rd = clk_3MHz_en && bus.should_read && hit_status;
  end

  always_comb begin
    bus.data_from_bram = '0;
    if (hit_latch)  bus.data_from_bram = latch;
    if (hit_status) bus.data_from_bram = {7'b0, overrun};
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (hit_gain[i]) bus.data_from_bram = gain[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latch <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) gain[i] <= 8'h80;
    end else if (wr_en) begin
      if (hit_latch) latch <= bus.data_to_bram;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (hit_gain[i]) gain[i] <= bus.data_to_bram;
      end
    end
  end

  // Set beats clear when a status read collides with a dropped tick
  always_ff @(posedge clk) begin
    if (rst)            overrun <= 1'b0;
    else if (ovr_set)   overrun <= 1'b1;
    else if (status_rd) overrun <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clk_24KHz_en) state_nx = ACCUM;
      ACCUM:   if (clk_3MHz_en && idx == IDX_W'(NUM_CH - 1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    snap_load = (state == IDLE) && clk_24KHz_en;
    acc_step  = (state == ACCUM) && clk_3MHz_en;
    finish    = (state == DONE);
    ovr_set   = (state != IDLE) && clk_24KHz_en;
  end

  always_comb begin
    prod    = ch_snap[int'(idx) * IN_W +: IN_W] * gain_snap[idx];
    v_w     = WIDE_W'(acc >> SHIFT);
    sat     = |(v_w >> OUT_W);
    mix_out = '0;
    if (latch[MUTE_BIT]) mix_out = sat ? '1 : v_w[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      idx          <= '0;
      ch_snap      <= '0;
      audio        <= '0;
      sample_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) gain_snap[i] <= '0;
    end else begin
      sample_valid <= finish;
      if (snap_load) begin
        ch_snap   <= ch_audio;
        gain_snap <= gain;
        acc       <= '0;
        idx       <= '0;
      end
      if (acc_step) begin
        acc <= acc + ACC_W'(prod);
        idx <= idx + 1'b1;
      end
      if (finish) audio <= mix_out;
    end
  end

endmodule

// File: tb/tb_sound_mixer_n.sv
// Directed bench for sound_mixer_n: a 16-bit and a 12-bit output instance
// share the same bus and channel stimulus.
module tb_sound_mixer_n;

  localparam logic [15:0] A = 16'h1840;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en3 = 1'b0;
  logic        tick24 = 1'b0;
  logic        should_read = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic [15:0] ch = 16'h0000;

  logic [7:0]  latch16, latch12;
  logic [15:0] audio16;
  logic [11:0] audio12;
  logic        sv16, sv12;

  int n_vec = 0;
  int n_bad = 0;
  int p16 = 0;
  int p12 = 0;

  sound_mixer_n_if bus16 ();
  sound_mixer_n_if bus12 ();

  assign bus16.should_read  = should_read;
  assign bus16.addr_to_bram = addr;
  assign bus16.data_to_bram = wdata;
  assign bus12.should_read  = should_read;
  assign bus12.addr_to_bram = addr;
  assign bus12.data_to_bram = wdata;

  sound_mixer_n u_dut16 (
    .clk(clk), .rst(rst), .clk_3MHz_en(en3), .clk_24KHz_en(tick24),
    .bus(bus16.slave), .ch_audio(ch), .latch_out(latch16),
    .audio(audio16), .sample_valid(sv16)
  );

  sound_mixer_n #(.OUT_W(12)) u_dut12 (
    .clk(clk), .rst(rst), .clk_3MHz_en(en3), .clk_24KHz_en(tick24),
    .bus(bus12.slave), .ch_audio(ch), .latch_out(latch12),
    .audio(audio12), .sample_valid(sv12)
  );

  always #5 clk = ~clk;

  // Free-running bus strobe, one clk in four
  initial begin
    int unsigned phase;
    phase = 0;
    forever begin
      @(negedge clk);
      en3 = (phase % 4 == 3);
      phase++;
    end
  end

  always @(negedge clk) begin
    if (sv16) p16++;
    if (sv12) p12++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    should_read = 1'b0;
    addr = a;
    wdata = d;
    repeat (4) @(negedge clk);
    should_read = 1'b1;
    addr = 16'h0000;
  endtask

  task automatic bus_read_chk(input logic [15:0] a, input logic [7:0] exp, input string name);
    @(negedge clk);
    should_read = 1'b1;
    addr = a;
    #1;
    check(name, {24'h0, bus16.data_from_bram}, {24'h0, exp});
    repeat (4) @(negedge clk);
    addr = 16'h0000;
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick24 = 1'b1;
    @(negedge clk);
    tick24 = 1'b0;
  endtask

  task automatic wait_pulse(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (p16 != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [15:0] ch;
    logic [31:0] gains;
    logic [7:0]  latch;
    logic [15:0] exp16;
    logic [11:0] exp12;
  } vec_t;

  vec_t vecs [9];

  initial begin
    bit ok;
    int b16, b12;

    // ch_i in ch[i*4+:4], gain_i in gains[i*8+:8]
    vecs[0] = '{16'h000F, 32'h80808080, 8'h20, 16'd1920,  12'd1920};
    vecs[1] = '{16'hFFFF, 32'hFFFFFFFF, 8'h20, 16'd15300, 12'hFFF};
    vecs[2] = '{16'hFFFF, 32'hFFFFFFFF, 8'h00, 16'd0,     12'd0};
    vecs[3] = '{16'h4321, 32'h10101010, 8'h21, 16'd160,   12'd160};
    vecs[4] = '{16'h0000, 32'hFFFFFFFF, 8'h20, 16'd0,     12'd0};
    vecs[5] = '{16'hFFFF, 32'h04030201, 8'h20, 16'd150,   12'd150};
    vecs[6] = '{16'h00FF, 32'hFFFFFFFF, 8'h3F, 16'd7650,  12'hFFF};
    vecs[7] = '{16'h00FF, 32'h000012FF, 8'h20, 16'd4095,  12'd4095};
    vecs[8] = '{16'h01FF, 32'h000112FF, 8'h20, 16'd4096,  12'hFFF};

    repeat (3) @(negedge clk);
    #1;
    check("rst_audio16", {16'h0, audio16}, 32'd0);
    check("rst_audio12", {20'h0, audio12}, 32'd0);
    check("rst_sv16", {31'h0, sv16}, 32'd0);
    check("rst_latch", {24'h0, latch16}, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus_read_chk(A + 16'(i), 8'h80, $sformatf("rst_gain%0d", i - 1));
    end
    bus_read_chk(A, 8'h00, "rst_latch_rd");
    bus_read_chk(A + 16'd5, 8'h00, "rst_status_rd");
    bus_read_chk(A + 16'd6, 8'h00, "unmapped_rd");

    for (int k = 0; k < 9; k++) begin
      bus_write(A, vecs[k].latch);
      for (int i = 0; i < 4; i++) begin
        bus_write(A + 16'(i + 1), vecs[k].gains[i*8 +: 8]);
      end
      bus_read_chk(A + 16'd1, vecs[k].gains[7:0], $sformatf("v%0d_gain0_rd", k));
      ch = vecs[k].ch;
      b16 = p16;
      b12 = p12;
      do_tick();
      wait_pulse(b16, ok);
      check($sformatf("v%0d_done_in_time", k), {31'h0, ok}, 32'd1);
      repeat (8) @(negedge clk);
      check($sformatf("v%0d_audio16", k), {16'h0, audio16}, {16'h0, vecs[k].exp16});
      check($sformatf("v%0d_audio12", k), {20'h0, audio12}, {20'h0, vecs[k].exp12});
      check($sformatf("v%0d_pulses16", k), p16 - b16, 32'd1);
      check($sformatf("v%0d_pulses12", k), p12 - b12, 32'd1);
      check($sformatf("v%0d_latch_out", k), {24'h0, latch16}, {24'h0, vecs[k].latch});
    end

    // Overrun: second tick and gain/channel changes land mid-accumulation
    bus_write(A, 8'h20);
    for (int i = 0; i < 4; i++) bus_write(A + 16'(i + 1), 8'h80);
    ch = 16'h000F;
    b16 = p16;
    do_tick();
    repeat (2) @(negedge clk);
    bus_write(A + 16'd1, 8'hFF);
    ch = 16'hFFFF;
    do_tick();
    wait_pulse(b16, ok);
    check("ovr_done_in_time", {31'h0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    check("ovr_audio16", {16'h0, audio16}, 32'd1920);
    repeat (40) @(negedge clk);
    check("ovr_single_pulse", p16 - b16, 32'd1);
    bus_read_chk(A + 16'd5, 8'h01, "ovr_status_set");
    bus_read_chk(A + 16'd5, 8'h00, "ovr_status_cleared");

    // Reset during accumulation aborts the sample
    ch = 16'h000F;
    b16 = p16;
    do_tick();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_audio16", {16'h0, audio16}, 32'd0);
    check("mid_rst_sv16", {31'h0, sv16}, 32'd0);
    check("mid_rst_latch", {24'h0, latch16}, 32'd0);
    repeat (40) @(negedge clk);
    check("mid_rst_no_pulse", p16 - b16, 32'd0);
    bus_read_chk(A + 16'd1, 8'h80, "mid_rst_gain0");
    bus_write(A, 8'h20);
    b16 = p16;
    do_tick();
    wait_pulse(b16, ok);
    check("post_rst_done_in_time", {31'h0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    check("post_rst_audio16", {16'h0, audio16}, 32'd1920);
    check("post_rst_audio12", {20'h0, audio12}, 32'd1920);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
